// File: rtl/therm_pkg.sv
// therm_pkg: shared states, default constants and decode helpers for the thermometer switch decoder
package therm_pkg;

    localparam int W             = 16;
    localparam int STABLE_CYCLES = 2000000;
    localparam int VW            = 5;

    typedef enum logic [1:0] {STABLE, SETTLE, COMMIT} state_t;

    function automatic logic [5:0] popcount(input logic [31:0] t);
        popcount = '0;
        for (int i = 0; i < 32; i++) popcount = popcount + 6'(t[i]);
    endfunction

    function automatic logic is_therm(input logic [31:0] t);
        logic [32:0] x;
        x = {1'b0, t};
        is_therm = ((x & (x + 33'd1)) == '0);
    endfunction

endpackage

// File: rtl/therm_sync_debounce.sv
// therm_sync_debounce: per-bit synchronizer and whole-vector debouncer emitting a one-cycle commit strobe
module therm_sync_debounce
    import therm_pkg::*;
#(
    parameter int W             = therm_pkg::W,
    parameter int STABLE_CYCLES = therm_pkg::STABLE_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_therm,
    output logic [W-1:0] o_vec,
    output logic         o_commit,
    output logic         o_busy
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;

    logic [W-1:0]  r_s1, r_s2, r_prev, r_vec;
    logic [CW-1:0] r_cnt;
    state_t        r_state;

    // two-flop synchronizer plus one-cycle history used to detect movement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= i_therm;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // commit the vector only after it has held still for STABLE_CYCLES; any movement restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_vec   <= '0;
        end else begin
            case (r_state)
                STABLE: if (r_s2 != r_vec) begin
                    r_cnt   <= '0;
                    r_state <= SETTLE;
                end
                SETTLE: if (r_s2 != r_prev) r_cnt <= '0;
                else if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
                    r_vec   <= r_s2;
                    r_state <= COMMIT;
                end else r_cnt <= r_cnt + 1'b1;
                default: r_state <= STABLE;
            endcase
        end
    end

    assign o_vec    = r_vec;
    assign o_commit = (r_state == COMMIT);
    assign o_busy   = (r_state == SETTLE);

endmodule

// File: rtl/therm_switch_decoder.sv
// therm_switch_decoder: debounced slide-switch thermometer code to binary level; THERM_BUBBLE_FIX_EN enables single-bubble correction
module therm_switch_decoder
    import therm_pkg::*;
#(
    parameter int W             = therm_pkg::W,
    parameter int STABLE_CYCLES = therm_pkg::STABLE_CYCLES,
    parameter int VW            = therm_pkg::VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  therm_in,
    output logic [VW-1:0] value,
    output logic          valid,
    output logic          err,
    output logic          upd,
    output logic          busy
);

    logic [W-1:0]  w_vec, w_fix;
    logic          w_commit, w_ok;
    logic [VW-1:0] w_pop;
    logic [VW-1:0] r_value;
    logic          r_valid, r_err, r_upd;

    therm_sync_debounce #(.W(W), .STABLE_CYCLES(STABLE_CYCLES)) u_deb (
        .clk      (clk),
        .rst      (rst),
        .i_therm  (therm_in),
        .o_vec    (w_vec),
        .o_commit (w_commit),
        .o_busy   (busy)
    );

`ifdef THERM_BUBBLE_FIX_EN
    logic [W+1:0] w_ext;
    assign w_ext = {1'b0, w_vec, 1'b1};
    // three-tap majority vote with a 1 below bit 0 and a 0 above the top bit
    always_comb begin
        w_fix = '0;
        for (int i = 0; i < W; i++)
            w_fix[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i+1] & w_ext[i+2]) | (w_ext[i] & w_ext[i+2]);
    end
`else
    assign w_fix = w_vec;
`endif

    assign w_ok  = is_therm(32'(w_fix));
    assign w_pop = VW'(popcount(32'(w_fix)));

    // update level/error on a commit; upd flags only a visible change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (w_commit) begin
                r_value <= w_ok ? w_pop : r_value;
                r_valid <= r_valid | w_ok;
                r_err   <= ~w_ok;
                r_upd   <= w_ok ? ((w_pop != r_value) | r_err) : ~r_err;
            end
        end
    end

    assign value = r_value;
    assign valid = r_valid;
    assign err   = r_err;
    assign upd   = r_upd;

endmodule

// File: tb/tb_therm_switch_decoder.sv
// tb_therm_switch_decoder: directed and randomized checks against a behavioural model of the decoder
module tb_therm_switch_decoder;

    localparam int W  = 16;
    localparam int SC = 8;
    localparam int VW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  therm_in = '0;
    logic [VW-1:0] value;
    logic          valid, err, upd, busy;

    int n_chk = 0;
    int n_fail = 0;
    int upd_total = 0;

    bit           m_bub;
    int           m_value;
    bit           m_err, m_valid;
    logic [W-1:0] m_last;

    therm_switch_decoder #(.W(W), .STABLE_CYCLES(SC), .VW(VW)) dut (
        .clk      (clk),
        .rst      (rst),
        .therm_in (therm_in),
        .value    (value),
        .valid    (valid),
        .err      (err),
        .upd      (upd),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (upd) upd_total <= upd_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int ones(input logic [W-1:0] t);
        int n = 0;
        for (int i = 0; i < W; i++) if (t[i]) n++;
        return n;
    endfunction

    function automatic logic [W-1:0] ref_fix(input logic [W-1:0] t);
        logic [W-1:0] f;
        int lo, hi;
        if (!m_bub) return t;
        for (int i = 0; i < W; i++) begin
            lo = (i == 0) ? 1 : int'(t[i-1]);
            hi = (i == W - 1) ? 0 : int'(t[i+1]);
            f[i] = (lo + int'(t[i]) + hi) >= 2;
        end
        return f;
    endfunction

    function automatic bit ref_ok(input logic [W-1:0] t);
        logic [31:0] mask;
        mask = (32'd1 << ones(t)) - 32'd1;
        return {16'd0, t} == mask;
    endfunction

    task automatic model_reset();
        m_value = 0;
        m_err   = 0;
        m_valid = 0;
        m_last  = '0;
    endtask

    task automatic model(input logic [W-1:0] t, output int exp_upd);
        logic [W-1:0] f;
        exp_upd = 0;
        if (t == m_last) return;
        m_last = t;
        f = ref_fix(t);
        if (ref_ok(f)) begin
            exp_upd = (ones(f) != m_value || m_err) ? 1 : 0;
            m_value = ones(f);
            m_err   = 0;
            m_valid = 1;
        end else begin
            exp_upd = m_err ? 0 : 1;
            m_err   = 1;
        end
    endtask

    task automatic check_out(input string tag);
        check({tag, " value"}, 32'(value), 32'(m_value));
        check({tag, " valid"}, 32'(valid), 32'(m_valid));
        check({tag, " err"}, 32'(err), 32'(m_err));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " value"}, 32'(value), 32'd0);
        check({tag, " valid"}, 32'(valid), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " upd"}, 32'(upd), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic hold(input logic [W-1:0] t, input string tag);
        int e, u0;
        model(t, e);
        u0 = upd_total;
        therm_in = t;
        tick(30);
        check({tag, " upd count"}, 32'(upd_total - u0), 32'(e));
        check_out(tag);
    endtask

    initial begin
        int cycles, e, u0, nb, g;
        logic [W-1:0] tgt, gv, pg;
        logic [31:0] tmp;
`ifdef THERM_BUBBLE_FIX_EN
        m_bub = 1;
`else
        m_bub = 0;
`endif
        model_reset();
        therm_in = 16'h00FF;
        rst = 1'b1;
        tick(1);
        check_reset_vals("in reset");
        tick(2);
        model(16'h00FF, e);
        rst = 1'b0;
        cycles = 0;
        while (!upd && cycles < 30) begin
            tick(1);
            cycles++;
            if (cycles == 1) check_reset_vals("after reset");
        end
        check("latency 10..12", 32'(cycles >= 10 && cycles <= 12), 32'd1);
        check_out("load 00FF");
        tick(1);
        check("upd single cycle", 32'(upd), 32'd0);
        hold(16'hFFFF, "full");
        hold(16'h0000, "zero");

        u0 = upd_total;
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            therm_in = ((k / 3) % 2) ? 16'h000F : 16'h0007;
            tick(1);
            if (k >= 3 && !busy) nb++;
        end
        check("bounce busy low cycles", 32'(nb), 32'd0);
        check("bounce upd count", 32'(upd_total - u0), 32'd0);
        hold(16'h000F, "bounce hold");

        hold(16'h8001, "invalid");
        hold(16'h0003, "recover");
        hold(16'h00FB, "bubble");

        u0 = upd_total;
        therm_in = 16'h003F;
        tick(7);
        check("mid-settle busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        check_reset_vals("mid-settle reset");
        tick(1);
        rst = 1'b0;
        check("mid-settle upd count", 32'(upd_total - u0), 32'd0);
        model_reset();
        hold(16'h003F, "post reset");

        pg = '0;
        for (int ep = 0; ep < 12; ep++) begin
            if ($urandom_range(0, 1) == 1) begin
                tmp = (32'd1 << $urandom_range(0, W)) - 32'd1;
                tgt = tmp[W-1:0];
            end else tgt = W'($urandom);
            g = $urandom_range(0, 4);
            u0 = upd_total;
            for (int j = 0; j < g; j++) begin
                do gv = W'($urandom); while (gv == pg);
                pg = gv;
                therm_in = gv;
                tick($urandom_range(1, 6));
            end
            check("glitch upd count", 32'(upd_total - u0), 32'd0);
            hold(tgt, "random");
            pg = tgt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/therm_switch_decoder.md
Name: therm_switch_decoder

Overview:
- Input-side counterpart of the counter's thermometer display path: reads a 16-bit thermometer code from board slide switches and returns the binary level.
- Per-bit 2-stage synchronizer, whole-vector debounce (vector must be stable for STABLE_CYCLES), contiguity check, then binary conversion.
- Output drives the load-data path of the existing counter logic.

Parameters:
- W, 16, thermometer width in bits.
- STABLE_CYCLES, 2000000, consecutive unchanged cycles required before commit (20 ms at 100 MHz).
- VW, 5, output value width; must satisfy 2**VW > W.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high; sampled on posedge clk only.
- therm_in  input  W  asynchronous switch vector; bit 0 is the lowest level.
- value  output  VW  binary level, 0..W; holds the last valid committed code.
- valid  output  1  high once any valid code has committed; stays high.
- err  output  1  high while the last committed vector is not a valid thermometer code.
- upd  output  1  one-cycle pulse when value or err changes at a commit.
- busy  output  1  high while the debouncer is settling.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset: sync flops, the previous-sample register and the counter clear to 0; FSM goes to STABLE. Outputs reset to value=0, valid=0, err=0, upd=0, busy=0.
- Reset mid-settle discards the pending vector; nothing commits.
- Sync: s1 <= therm_in and s2 <= s1, per bit. Only s2 is used downstream.
- Registers: prev <= s2 every cycle. Counter is a saturating counter of width clog2(STABLE_CYCLES)+1.
- FSM states: STABLE, SETTLE, COMMIT.
  - STABLE: if s2 != committed vector, clear counter and go to SETTLE. Otherwise stay.
  - SETTLE: busy=1. If s2 != prev, clear counter and stay. Otherwise increment. When the counter reaches STABLE_CYCLES-1 and s2 == prev, go to COMMIT.
  - SETTLE, simultaneous change and terminal count: the change wins and the counter restarts.
  - COMMIT (one cycle): latch the committed vector, run the check and decode below, go to STABLE.
- Validity: vector t is valid iff (t & (t+1)) == 0 at W+1 bits, i.e. all ones are contiguous from bit 0.
- Decode: value = popcount(t), range 0..W. 0x0000 gives 0; 0xFFFF gives 16.
- On COMMIT:
  - Valid code: value updates, err=0, valid=1.
  - Invalid code: value holds, err=1, valid is unchanged.
  - upd=1 for the COMMIT cycle only if value or err changed.
- Latency: therm_in change to upd = 2 sync + STABLE_CYCLES + 1 cycles (±1 for sampling phase).
- A commit whose code equals the previous commit gives no upd.

Optional Feature:
- Macro: THERM_BUBBLE_FIX_EN.
- Defined: before the validity check, t'[i] = majority(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[W]=0. Isolated single-bit bubbles are corrected, e.g. 0x00FB becomes 0x00FF and value=8 with err=0. Adds no latency; correction is combinational within COMMIT.
- Undefined: the raw vector is checked; 0x00FB gives err=1 and value holds.

Decomposition:
- Package therm_pkg holds:
  - State enum: STABLE, SETTLE, COMMIT.
  - Default constants: W, STABLE_CYCLES, VW.
  - Function popcount.
  - Function is_therm.
- Sub-module therm_sync_debounce: synchronizer, prev register, counter and FSM. It outputs a stable vector plus a one-cycle commit strobe.
- Top level therm_switch_decoder: bubble fix, validity check, decode and output registers.

Test Plan:
- All benches use STABLE_CYCLES=8.
- Reset: rst high for 3 cycles with therm_in=0x00FF. Required: value=0, valid=0, err=0, upd=0, busy=0 during reset and in the first cycle after release.
- Valid load: therm_in=0x00FF held. Required: upd pulse 11±1 cycles later, value=8, valid=1, err=0. Then 0xFFFF gives value=16; 0x0000 gives value=0.
- Bounce: toggle therm_in between 0x0007 and 0x000F every 3 cycles for 40 cycles, then hold 0x000F. Required: busy=1 throughout the toggling, no upd during toggling, exactly one upd after the hold, value=4.
- Invalid code: from value=4, apply 0x8001. Required: err=1 with a single upd pulse and value stays 4. Then 0x0003 gives err=0, value=2, upd pulse.
- Bubble, run once with THERM_BUBBLE_FIX_EN defined and once without: apply 0x00FB. Defined: value=8, err=0. Undefined: err=1 and value unchanged.
- Reset mid-settle: apply 0x003F, assert rst at counter=4. Required: no commit and outputs at reset values. After release with 0x003F still held, commit gives value=6.
